// File: rtl/tt_unswap.sv
// tt_unswap: recovers lanes a/b from a pair of scrambled lanes c/d.
// A key bit from an 8-bit Fibonacci LFSR says whether c/d were swapped.
// The LFSR restarts from the seed register at the start of every frame of
// FRAME_LEN pairs. The block stays in IDLE until the first load_seed.
//
// Parameters:
//   SEED      - seed used at reset and when a zero seed is loaded
//   FRAME_LEN - pairs per frame (2..256)
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   load_seed, seed      - load the key seed and (re)start a frame
//   in_c, in_d, in_valid - scrambled input pair; in_ready accepts it
//   out_a, out_b         - recovered pair, out_valid/out_ready handshake
//   frame_end            - output pair is the last of its frame
//   locked               - block is in RUN
//   in_par, par_err      - frame parity check, only with TT_UNSWAP_PARITY_EN
// Optional feature macro: TT_UNSWAP_PARITY_EN
module tt_unswap #(
    parameter logic [7:0]  SEED      = 8'hA5,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_seed,
    input  logic [7:0] seed,
    input  logic       in_c,
    input  logic       in_d,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_a,
    output logic       out_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_end,
`ifdef TT_UNSWAP_PARITY_EN
    input  logic       in_par,
    output logic       par_err,
`endif
    output logic       locked
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic             state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [7:0]       seed_q, seed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_a_q, out_a_d;
    logic             out_b_q, out_b_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_end_q, frame_end_d;

    logic       xfer;
    logic       last_beat;
    logic       key;
    logic       res_a;
    logic       res_b;
    logic [7:0] lfsr_step;
    logic [7:0] seed_eff;

    assign key       = lfsr_q[0];
    assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign seed_eff  = (seed == 8'h00) ? SEED : seed;
    assign last_beat = (cnt_q == CNT_LAST);
    assign res_a     = key ? in_d : in_c;
    assign res_b     = key ? in_c : in_d;

    // load_seed blocks acceptance, so it always wins over a transfer.
    assign in_ready = (state_q == ST_RUN) && !load_seed && (!out_valid_q || out_ready);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        seed_d      = seed_q;
        cnt_d       = cnt_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_valid_d = out_valid_q;
        frame_end_d = frame_end_q;

        // Drain first; a same-cycle transfer below refills the output.
        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (load_seed) begin
            state_d = ST_RUN;
            seed_d  = seed_eff;
            lfsr_d  = seed_eff;
            cnt_d   = '0;
        end else if (xfer) begin
            out_a_d     = res_a;
            out_b_d     = res_b;
            out_valid_d = 1'b1;
            frame_end_d = last_beat;
            if (last_beat) begin
                cnt_d  = '0;
                lfsr_d = seed_q;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                lfsr_d = lfsr_step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= SEED;
            seed_q      <= SEED;
            cnt_q       <= '0;
            out_a_q     <= 1'b0;
            out_b_q     <= 1'b0;
            out_valid_q <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            seed_q      <= seed_d;
            cnt_q       <= cnt_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_valid_q <= out_valid_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_valid = out_valid_q;
    assign frame_end = frame_end_q;
    assign locked    = (state_q == ST_RUN);

`ifdef TT_UNSWAP_PARITY_EN
    logic par_acc_q, par_acc_d;
    logic par_err_q, par_err_d;
    logic par_full;

    // Parity over the whole frame, including the pair being accepted now.
    assign par_full = par_acc_q ^ res_a ^ res_b;

    always_comb begin
        par_acc_d = par_acc_q;
        par_err_d = par_err_q;
        if (load_seed) begin
            par_acc_d = 1'b0;
        end else if (xfer) begin
            if (last_beat) begin
                par_acc_d = 1'b0;
                par_err_d = (in_par != par_full);
            end else begin
                par_acc_d = par_full;
                par_err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_acc_q <= par_acc_d;
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_tt_unswap.sv
// Self-checking bench for tt_unswap (default build, parity feature off).
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level reference model: the key for a pair is derived from the
// frame seed and the pair's index inside the frame.
module tb_tt_unswap;

    localparam int unsigned FRAME_LEN = 16;
    localparam logic [7:0]  SEED      = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_seed;
    logic [7:0] seed;
    logic       in_c;
    logic       in_d;
    logic       in_valid;
    logic       in_ready;
    logic       out_a;
    logic       out_b;
    logic       out_valid;
    logic       out_ready;
    logic       frame_end;
    logic       locked;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit         m_locked;
    logic [7:0] m_seed;
    int         m_beat;
    bit         m_ov;
    bit         m_a;
    bit         m_b;
    bit         m_fe;

    tt_unswap #(
        .SEED      (SEED),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_seed (load_seed),
        .seed      (seed),
        .in_c      (in_c),
        .in_d      (in_d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_end (frame_end),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Key bit for pair number n of a frame started from seed s.
    function automatic bit key_at(input logic [7:0] s, input int n);
        logic [7:0] l;
        l = s;
        for (int i = 0; i < n; i++) begin
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        return l[0];
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_seed   = SEED;
        m_beat   = 0;
        m_ov     = 1'b0;
        m_a      = 1'b0;
        m_b      = 1'b0;
        m_fe     = 1'b0;
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("locked", 32'(locked), 32'(m_locked));
        if (m_ov) begin
            check("out_a", 32'(out_a), 32'(m_a));
            check("out_b", 32'(out_b), 32'(m_b));
            check("frame_end", 32'(frame_end), 32'(m_fe));
        end
    endtask

    // One clock cycle starting and ending at a falling edge.
    task automatic do_cycle(input bit ls, input logic [7:0] sd, input bit iv,
                            input bit c, input bit d, input bit ordy);
        bit exp_rdy;
        bit k;
        load_seed = ls;
        seed      = sd;
        in_valid  = iv;
        in_c      = c;
        in_d      = d;
        out_ready = ordy;
        #1;
        exp_rdy = m_locked && !ls && (!m_ov || ordy);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (ordy) m_ov = 1'b0;
        if (ls) begin
            m_locked = 1'b1;
            m_seed   = (sd == 8'h00) ? SEED : sd;
            m_beat   = 0;
        end else if (iv && exp_rdy) begin
            k    = key_at(m_seed, m_beat);
            m_a  = k ? d : c;
            m_b  = k ? c : d;
            m_fe = (m_beat == FRAME_LEN - 1);
            m_ov = 1'b1;
            m_beat = m_fe ? 0 : m_beat + 1;
        end
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous reset pulse starting at a falling edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_a", 32'(out_a), 32'd0);
        check("rst_out_b", 32'(out_b), 32'd0);
        check("rst_frame_end", 32'(frame_end), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic sa;
        logic sb;
        rst_n     = 1'b0;
        load_seed = 1'b0;
        seed      = 8'h00;
        in_c      = 1'b0;
        in_d      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        pulse_reset();

        // Idle: input offered but never accepted before load_seed.
        do_cycle(0, 8'h00, 1, 1, 0, 1);

        // Seed A5: first key 1, second key 0.
        do_cycle(1, 8'hA5, 0, 0, 0, 1);
        do_cycle(0, 8'h00, 1, 1, 0, 1);
        check("req040_a0", 32'(out_a), 32'd0);
        check("req040_b0", 32'(out_b), 32'd1);
        do_cycle(0, 8'h00, 1, 1, 0, 1);
        check("req040_a1", 32'(out_a), 32'd1);
        check("req040_b1", 32'(out_b), 32'd0);

        // Zero seed falls back to SEED.
        do_cycle(1, 8'h00, 0, 0, 0, 1);
        do_cycle(0, 8'h00, 1, 1, 0, 1);
        check("req041_a0", 32'(out_a), 32'd0);
        check("req041_b0", 32'(out_b), 32'd1);
        do_cycle(0, 8'h00, 1, 1, 0, 1);
        check("req041_a1", 32'(out_a), 32'd1);

        // Full frame back to back, then first pair of the next frame.
        do_cycle(1, 8'hA5, 0, 0, 0, 1);
        for (int i = 0; i < FRAME_LEN + 1; i++) begin
            do_cycle(0, 8'h00, 1, 1, 0, 1);
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_frame_end", 32'(frame_end), 32'(i == FRAME_LEN - 1));
        end
        check("wrap_a", 32'(out_a), 32'd0);
        check("wrap_b", 32'(out_b), 32'd1);

        // Backpressure: outputs held while stalled.
        sa = out_a;
        sb = out_b;
        for (int i = 0; i < 3; i++) begin
            do_cycle(0, 8'h00, 1, 0, 1, 0);
            check("stall_a", 32'(out_a), 32'(sa));
            check("stall_b", 32'(out_b), 32'(sb));
        end
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 8'h00, 1, i[0], ~i[1], 1);
        end

        // Reset mid-frame with a pending output.
        do_cycle(0, 8'h00, 1, 1, 1, 0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        pulse_reset();
        do_cycle(0, 8'h00, 1, 1, 0, 1);
        do_cycle(0, 8'h00, 1, 0, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                pulse_reset();
            end else begin
                bit ls;
                logic [7:0] sd;
                ls = ($urandom_range(0, 29) == 0) || !m_locked;
                sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                do_cycle(ls, sd, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                         $urandom_range(0, 3) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tt_unswap.md
TT_UNSWAP -- requirements
Module: tt_unswap

Interface
REQ-001 SHALL provide parameter SEED, default 8'hA5, meaning the LFSR seed used when the loaded seed is zero.
REQ-002 SHALL provide parameter FRAME_LEN, default 16, meaning the number of pairs per frame; legal range 2..256.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port load_seed  input  1  a one-cycle request to load seed and start a frame.
REQ-006 SHALL have port seed  input  8  the key-stream seed, sampled when load_seed is high.
REQ-007 SHALL have port in_c  input  1  the scrambled lane c.
REQ-008 SHALL have port in_d  input  1  the scrambled lane d.
REQ-009 SHALL have port in_valid  input  1  meaning in_c and in_d are valid.
REQ-010 SHALL have port in_ready  output  1  meaning the block accepts a pair this cycle.
REQ-011 SHALL have port out_a  output  1  the recovered lane a.
REQ-012 SHALL have port out_b  output  1  the recovered lane b.
REQ-013 SHALL have port out_valid  output  1  meaning out_a and out_b are valid.
REQ-014 SHALL have port out_ready  input  1  meaning the downstream block accepts the output.
REQ-015 SHALL have port frame_end  output  1  meaning the current output is the last pair of the frame; qualified by out_valid.
REQ-016 SHALL have port locked  output  1  meaning state is RUN.

Function
REQ-017 SHALL implement states IDLE and RUN: IDLE->RUN on load_seed; RUN stays in RUN, and load_seed in RUN reloads.
REQ-018 In IDLE, in_ready SHALL be 0.
REQ-019 In RUN, in_ready SHALL equal !load_seed && (!out_valid || out_ready).
REQ-020 A transfer SHALL occur when in_valid && in_ready.
REQ-021 The key stream SHALL come from an 8-bit Fibonacci LFSR: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; key bit = lfsr[0].
REQ-022 On a transfer, unscrambling SHALL be: key 0 -> a=c, b=d; key 1 -> a=d, b=c.
REQ-023 The result of REQ-022 SHALL be registered into out_a and out_b with out_valid=1 on the next edge (latency 1), and the LFSR SHALL advance one step.
REQ-024 out_valid SHALL stay high with stable out_a, out_b and frame_end until out_ready.
REQ-025 out_valid SHALL clear on out_ready when there is no simultaneous transfer.
REQ-026 Transfer and output drain in the same cycle SHALL give full throughput: one pair per cycle.
REQ-027 The beat counter SHALL count 0..FRAME_LEN-1 and increment per transfer.
REQ-028 On the transfer at count FRAME_LEN-1: the counter wraps to 0, the LFSR reloads from the seed register, and frame_end=1 accompanies that output.
REQ-029 On load_seed: the seed register = (seed==0) ? SEED : seed; the LFSR is loaded with the same value; the counter is cleared next edge.
REQ-030 A pending output SHALL be kept when load_seed is asserted.
REQ-031 load_seed SHALL take priority over a transfer in the same cycle, since in_ready=0 then.

Reset
REQ-032 While rst_n=0: state=IDLE, LFSR=SEED, seed register=SEED, counter=0, out_a=0, out_b=0, out_valid=0, frame_end=0, locked=0, in_ready=0.
REQ-033 Reset SHALL take effect immediately (asynchronous), including mid-frame and while out_valid=1; any pending output is discarded.
REQ-034 Reset release SHALL be synchronised by the integrator; the block SHALL leave IDLE only via load_seed.

Configuration
REQ-035 Macro TT_UNSWAP_PARITY_EN defined SHALL add input in_par (1-bit, sampled on the last transfer of a frame) and output par_err (1-bit).
REQ-036 With TT_UNSWAP_PARITY_EN defined, the block SHALL keep a running XOR of out_a^out_b over the frame.
REQ-037 With TT_UNSWAP_PARITY_EN defined, par_err SHALL be 1 alongside a frame_end output when in_par != running XOR, and held with that output.
REQ-038 With TT_UNSWAP_PARITY_EN defined, the running XOR SHALL be cleared at frame wrap, on load_seed and on reset; par_err resets to 0.
REQ-039 With TT_UNSWAP_PARITY_EN undefined, in_par, par_err and the parity logic SHALL be absent, with all other behaviour identical.

Verification
REQ-040 load_seed with seed=8'hA5, then in_c=1, in_d=0 -> next cycle out_a=0, out_b=1 (key 1); then in_c=1, in_d=0 -> out_a=1, out_b=0 (LFSR=8'h4A, key 0).
REQ-041 load_seed with seed=8'h00 -> LFSR=8'hA5; output matches REQ-040.
REQ-042 FRAME_LEN=16, 16 back-to-back transfers with out_ready=1 -> one output per cycle, frame_end only on the 16th; the 17th pair is unscrambled with key 1 again (reseed to 8'hA5).
REQ-043 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no LFSR advance; on out_ready=1 the stream resumes with no loss or duplication.
REQ-044 rst_n pulled low mid-frame with out_valid=1 -> all outputs 0 at once, locked=0; in_ready stays 0 until load_seed.
REQ-045 With TT_UNSWAP_PARITY_EN: frame of 16 pairs with wrong in_par -> par_err=1 together with frame_end; with correct in_par -> par_err=0.
